// File: rtl/scan_pkg.sv
// Shared definitions for the decoder scan controller: FSM encoding, channel
// geometry and the mapping of channel-index bits onto the decoder select pins.
package scan_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned CH_W   = 3;

    localparam int unsigned SEL_E_BIT  = 2;
    localparam int unsigned SEL_X0_BIT = 1;
    localparam int unsigned SEL_X1_BIT = 0;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoad    = 2'd1,
        StDwell   = 2'd2,
        StAdvance = 2'd3
    } scan_state_e;

endpackage

// File: rtl/scan_next_ch.sv
// Combinational channel search: lowest enabled channel, and the next enabled
// channel strictly above the current one (wrapping to the lowest when none).
module scan_next_ch
    import scan_pkg::*;
(
    input  logic [CH_W-1:0]   ch_i,
    input  logic [NUM_CH-1:0] mask_i,
    output logic [CH_W-1:0]   nxt_o,
    output logic              wrap_o,
    output logic [CH_W-1:0]   first_o
);

    logic            found_first;
    logic            found_nxt;
    logic [CH_W-1:0] above;

    always_comb begin
        first_o     = '0;
        found_first = 1'b0;
        above       = '0;
        found_nxt   = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (mask_i[i] && !found_first) begin
                first_o     = CH_W'(i);
                found_first = 1'b1;
            end
            if (mask_i[i] && (i > int'(ch_i)) && !found_nxt) begin
                above     = CH_W'(i);
                found_nxt = 1'b1;
            end
        end
        wrap_o = !found_nxt;
        nxt_o  = found_nxt ? above : first_o;
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Sequencer driving the {E, x0, x1} select inputs of a 3-to-8 decoder through
// the enabled channels with a programmable dwell, in single or continuous mode.
module decoder_scan_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 8,
    parameter int unsigned NUM_CH  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NUM_CH-1:0]  mask,
    output logic               E,
    output logic               x0,
    output logic               x1,
    output logic               sel_valid,
    output logic               busy,
    output logic               step,
    output logic               done
);

    scan_state_e state_q, state_d;

    logic [CH_W-1:0]    ch_q, ch_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic               mode_q, mode_d;
    logic               sel_valid_q, sel_valid_d;
    logic               busy_q, busy_d;
    logic               step_q, step_d;
    logic               done_q, done_d;

    logic [CH_W-1:0] nxt_ch;
    logic [CH_W-1:0] first_ch;
    logic            wrap;
    logic            accept;

    scan_next_ch u_next_ch (
        .ch_i    (ch_q),
        .mask_i  (mask_q),
        .nxt_o   (nxt_ch),
        .wrap_o  (wrap),
        .first_o (first_ch)
    );

    assign accept = start && (|mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = StLoad;
            StLoad:    state_d = stop ? StIdle : StDwell;
            StDwell: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StAdvance;
                end
            end
            StAdvance: begin
                if (stop || (wrap && !mode_q)) begin
                    state_d = StIdle;
                end else begin
                    state_d = StDwell;
                end
            end
            default:   state_d = StIdle;
        endcase
    end

    // Next values for the registered outputs and the latched sweep setup.
    always_comb begin
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        dwell_d     = dwell_q;
        mask_d      = mask_q;
        mode_d      = mode_q;
        sel_valid_d = sel_valid_q;
        step_d      = 1'b0;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    dwell_d = dwell;
                    mask_d  = mask;
                    mode_d  = mode;
                end
            end
            StLoad: begin
                if (stop) begin
                    sel_valid_d = 1'b0;
                end else begin
                    ch_d        = first_ch;
                    cnt_d       = dwell_q;
                    sel_valid_d = 1'b1;
                    step_d      = 1'b1;
                end
            end
            StDwell: begin
                if (stop) begin
                    sel_valid_d = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StAdvance: begin
                if (stop) begin
                    sel_valid_d = 1'b0;
                end else if (wrap && !mode_q) begin
                    sel_valid_d = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    ch_d   = nxt_ch;
                    cnt_d  = dwell_q;
                    step_d = 1'b1;
                end
            end
            default: sel_valid_d = 1'b0;
        endcase
        // busy stays up through the done cycle and drops on the cycle after it.
        busy_d = (state_d != StIdle) || done_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q        <= '0;
            cnt_q       <= '0;
            dwell_q     <= '0;
            mask_q      <= '0;
            mode_q      <= 1'b0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            dwell_q     <= dwell_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            step_q      <= step_d;
            done_q      <= done_d;
        end
    end

    assign E         = ch_q[SEL_E_BIT];
    assign x0        = ch_q[SEL_X0_BIT];
    assign x1        = ch_q[SEL_X1_BIT];
    assign sel_valid = sel_valid_q;
    assign busy      = busy_q;
    assign step      = step_q;
    assign done      = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: hand-computed expectations checked with
// immediate assertions, sampled 1 time unit after each rising clock edge.
module tb_decoder_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] dwell;
    logic [7:0] mask;
    logic       E, x0, x1;
    logic       sel_valid, busy, step, done;

    int n_checks = 0;
    int n_fail   = 0;

    decoder_scan_ctrl #(
        .DWELL_W (8),
        .NUM_CH  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .dwell     (dwell),
        .mask      (mask),
        .E         (E),
        .x0        (x0),
        .x1        (x1),
        .sel_valid (sel_valid),
        .busy      (busy),
        .step      (step),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        // {E, x0, x1, sel_valid, busy, step, done}
        return {1'b0, E, x0, x1, sel_valid, busy, step, done};
    endfunction

    task automatic go(input logic [7:0] m, input logic [7:0] d, input logic md);
        mask  = m;
        dwell = d;
        mode  = md;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [2:0] seq3 [7];

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 1'b0;
        dwell = 8'd0;
        mask  = 8'd0;
        tick();
        tick();
        chk("reset_outputs", outs(), 8'h00);
        #3 rst = 1'b0;
        tick();
        chk("post_reset_idle", outs(), 8'h00);

        // Async reset mid-DWELL on channel 5.
        go(8'h20, 8'd10, 1'b0);
        chk("ch5_load_busy", {7'd0, busy}, 8'h01);
        tick();
        chk("ch5_dwell", outs(), 8'h5E);
        tick();
        chk("ch5_dwell2", outs(), 8'h5C);
        #3 rst = 1'b1;
        #1 chk("async_reset_clear", outs(), 8'h00);
        #2 rst = 1'b0;
        tick();
        chk("idle_after_reset", outs(), 8'h00);

        // Single sweep, all channels, dwell=2.
        go(8'hFF, 8'd2, 1'b0);
        chk("ff_load", outs(), 8'h04);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("ff_step_ch%0d", c), outs(), {1'b0, 3'(c), 4'b1110});
            tick();
            chk($sformatf("ff_hold1_ch%0d", c), outs(), {1'b0, 3'(c), 4'b1100});
            tick();
            chk($sformatf("ff_hold2_ch%0d", c), outs(), {1'b0, 3'(c), 4'b1100});
            tick();
            chk($sformatf("ff_adv_ch%0d", c), outs(), {1'b0, 3'(c), 4'b1100});
        end
        tick();
        chk("ff_done_pulse", outs(), 8'h75);
        tick();
        chk("ff_idle_after_done", outs(), 8'h70);

        // Continuous, sparse mask, dwell=0: 2,5,7,2,5,7,2 then stop.
        seq3[0] = 3'd2; seq3[1] = 3'd5; seq3[2] = 3'd7; seq3[3] = 3'd2;
        seq3[4] = 3'd5; seq3[5] = 3'd7; seq3[6] = 3'd2;
        go(8'b1010_0100, 8'd0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("cont_step_%0d", k), outs(), {1'b0, seq3[k], 4'b1110});
            tick();
            chk($sformatf("cont_adv_%0d", k), outs(), {1'b0, seq3[k], 4'b1100});
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("cont_stop", outs(), 8'h20);

        // Empty mask: start ignored.
        go(8'h00, 8'd3, 1'b0);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("empty_mask_%0d", k), {5'd0, busy, step, done}, 8'h00);
            tick();
        end

        // Stop coincident with the final ADVANCE on ch 7.
        go(8'h81, 8'd1, 1'b0);
        tick();
        chk("stop_ch0_step", outs(), 8'h0E);
        tick();
        tick();
        chk("stop_ch0_adv", outs(), 8'h0C);
        tick();
        chk("stop_ch7_step", outs(), 8'h7E);
        tick();
        tick();
        chk("stop_ch7_adv", outs(), 8'h7C);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_wins_over_done", outs(), 8'h70);
        tick();
        chk("stop_stays_idle", outs(), 8'h70);

        // Start while busy is ignored; new mask taken only once back in IDLE.
        go(8'h03, 8'd0, 1'b0);
        mask  = 8'hC0;
        mode  = 1'b1;
        dwell = 8'd5;
        start = 1'b1;
        tick();
        chk("busy_start_ch0", outs(), 8'h0E);
        tick();
        tick();
        chk("busy_start_ch1", outs(), 8'h1E);
        tick();
        tick();
        chk("busy_start_done", outs(), 8'h15);
        tick();
        start = 1'b0;
        chk("restart_load", outs(), 8'h14);
        tick();
        chk("restart_ch6", outs(), 8'h6E);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("restart_stop", outs(), 8'h60);

        // Stop in IDLE has no effect; start+stop together: start wins.
        stop  = 1'b1;
        tick();
        chk("idle_stop_noop", outs(), 8'h60);
        mask  = 8'h10;
        dwell = 8'd0;
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_beats_stop", {7'd0, busy}, 8'h01);
        tick();
        chk("start_beats_stop_ch4", outs(), 8'h4E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
